// File: rtl/id_ex_queue_pkg.sv
// Shared ID->EX definitions: default bubble instruction, load opcodes and payload field layout.
// EX unpacks the payload using the same offsets.
package id_ex_queue_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [6:0]  OPC_LOAD     = 7'b0000011;
    localparam logic [6:0]  OPC_FLW      = 7'b0000111;

    // Payload layout, LSB first: pc, rd1, rd2, fd1, fd2, fd3, imm, br_taken
    localparam int PL_PC_LSB    = 0;
    localparam int PL_RD1_LSB   = 32;
    localparam int PL_RD2_LSB   = 64;
    localparam int PL_FD1_LSB   = 96;
    localparam int PL_FD2_LSB   = 128;
    localparam int PL_FD3_LSB   = 160;
    localparam int PL_IMM_LSB   = 192;
    localparam int PL_BR_BIT    = 224;
    localparam int PAYLOAD_W_DEF = 225;

    function automatic logic is_load_op(input logic [31:0] inst);
        return (inst[6:0] == OPC_LOAD) || (inst[6:0] == OPC_FLW);
    endfunction

endpackage

// File: rtl/queue_hazard_cmp.sv
// Per-entry load-use comparator: flags a queued load whose rd is read by the decoding instruction.
module queue_hazard_cmp (
    input  logic       vld,
    input  logic       is_load,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       match
);

    assign match = vld & is_load & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));

endmodule

// File: rtl/id_ex_queue.sv
// Elastic ID->EX queue: circular flop buffer with valid/ready handshake, flush,
// NOP bubble on empty, and load-use hazard detection against every queued load.
module id_ex_queue
    import id_ex_queue_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter int          PAYLOAD_W = PAYLOAD_W_DEF,
    parameter logic [31:0] NOP_INST  = NOP_INST_DEF,
    localparam int         CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [31:0]          dec_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     count,
    output logic                 load_hazard
);

    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]          inst_q    [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [4:0]           rd_q      [DEPTH];
    logic [DEPTH-1:0]     is_load_q;
    logic [DEPTH-1:0]     vld_q;
    logic [DEPTH-1:0]     match_vec;

    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic             in_ready_q;
    logic             push, pop;
    logic             unused_dec;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (count_q != '0);
    assign in_ready  = in_ready_q;
    assign count     = count_q;
    assign push      = in_valid & in_ready_q & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Control state: pointers, occupancy, entry valids
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            vld_q      <= '0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            vld_q      <= '0;
        end else begin
            if (push) begin
                vld_q[wptr] <= 1'b1;
                wptr        <= ptr_inc(wptr);
            end
            if (pop) begin
                vld_q[rptr] <= 1'b0;
                rptr        <= ptr_inc(rptr);
            end
            count_q    <= count_nxt;
            in_ready_q <= (count_nxt != FULL_CNT);
        end
    end

    // Entry data is only ever observed through vld_q, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wptr]    <= in_inst;
            payload_q[wptr] <= in_payload;
            is_load_q[wptr] <= is_load_op(in_inst);
            rd_q[wptr]      <= in_inst[11:7];
        end
    end

    assign out_inst    = out_valid ? inst_q[rptr]    : NOP_INST;
    assign out_payload = out_valid ? payload_q[rptr] : '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_hazard
        queue_hazard_cmp u_cmp (
            .vld     (vld_q[g]),
            .is_load (is_load_q[g]),
            .rd      (rd_q[g]),
            .rs1     (dec_inst[19:15]),
            .rs2     (dec_inst[24:20]),
            .match   (match_vec[g])
        );
    end

    assign load_hazard = |match_vec;
    assign unused_dec  = ^{dec_inst[31:25], dec_inst[14:0]};

endmodule

// File: tb/tb_id_ex_queue.sv
// Directed bench for id_ex_queue: DEPTH=2 handshake/hazard/flush/reset and DEPTH=3 wrap-around.
module tb_id_ex_queue;

    localparam int PW = 225;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic          d2_flush = 1'b0, d2_in_valid = 1'b0, d2_out_ready = 1'b0;
    logic          d2_in_ready, d2_out_valid, d2_load_hazard;
    logic [31:0]   d2_in_inst = 32'h0, d2_dec_inst = 32'h0, d2_out_inst;
    logic [PW-1:0] d2_in_payload = '0, d2_out_payload;
    logic [1:0]    d2_count;

    // DEPTH=3 instance
    logic          d3_flush = 1'b0, d3_in_valid = 1'b0, d3_out_ready = 1'b0;
    logic          d3_in_ready, d3_out_valid, d3_load_hazard;
    logic [31:0]   d3_in_inst = 32'h0, d3_dec_inst = 32'h0, d3_out_inst;
    logic [PW-1:0] d3_in_payload = '0, d3_out_payload;
    logic [1:0]    d3_count;

    id_ex_queue #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(d2_flush),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .in_inst(d2_in_inst), .in_payload(d2_in_payload),
        .dec_inst(d2_dec_inst),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .out_inst(d2_out_inst), .out_payload(d2_out_payload),
        .count(d2_count), .load_hazard(d2_load_hazard)
    );

    id_ex_queue #(.DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush(d3_flush),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .in_inst(d3_in_inst), .in_payload(d3_in_payload),
        .dec_inst(d3_dec_inst),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .out_inst(d3_out_inst), .out_payload(d3_out_payload),
        .count(d3_count), .load_hazard(d3_load_hazard)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_A = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] INST_B = 32'h00A0_0113;  // addi x2,x0,10
    localparam logic [31:0] INST_C = 32'h0010_0393;  // addi x7,x0,1
    localparam logic [31:0] LW_X5  = 32'h0000_A283;  // lw x5,0(x1)
    localparam logic [31:0] FLW_F7 = 32'h0000_A387;  // flw f7,0(x1)
    localparam logic [31:0] ADD_RS1_X5 = 32'h0022_8333;  // add x6,x5,x2
    localparam logic [31:0] ADD_RS2_X5 = 32'h0051_0333;  // add x6,x2,x5
    localparam logic [31:0] ADD_X0_X7  = 32'h0070_0333;  // add x6,x0,x7
    localparam logic [PW-1:0] PL_A = {1'b1, 32'hDEAD_BEEF, 160'h0, 32'h0000_1000};
    localparam logic [PW-1:0] PL_B = {1'b0, 32'h1234_5678, 160'h5, 32'h0000_1004};

    task automatic d2_push(input logic [31:0] inst, input logic [PW-1:0] pl);
        d2_in_valid   = 1'b1;
        d2_in_inst    = inst;
        d2_in_payload = pl;
        step();
        d2_in_valid   = 1'b0;
    endtask

    function automatic logic [31:0] wrap_inst(input int i);
        return {12'(i + 1), 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    initial begin
        // Reset then idle
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_out_valid", 256'(d2_out_valid), 256'(1'b0));
        check("rst_out_inst",  256'(d2_out_inst),  256'(NOP));
        check("rst_count",     256'(d2_count),     256'(2'd0));
        check("rst_in_ready",  256'(d2_in_ready),  256'(1'b1));
        check("rst_payload",   256'(d2_out_payload), 256'(0));
        check("rst_hazard",    256'(d2_load_hazard), 256'(1'b0));

        // Fill DEPTH=2 with out_ready low
        d2_push(INST_A, PL_A);
        check("a_count",   256'(d2_count),       256'(2'd1));
        check("a_inst",    256'(d2_out_inst),    256'(INST_A));
        check("a_payload", 256'(d2_out_payload), 256'(PL_A));
        d2_push(INST_B, PL_B);
        check("full_count",    256'(d2_count),    256'(2'd2));
        check("full_in_ready", 256'(d2_in_ready), 256'(1'b0));

        // Drain; a push offered while full is not accepted
        d2_out_ready  = 1'b1;
        d2_in_valid   = 1'b1;
        d2_in_inst    = INST_C;
        d2_in_payload = PL_A;
        check("drain_head_a", 256'(d2_out_inst), 256'(INST_A));
        step();
        d2_in_valid = 1'b0;
        check("drain_head_b",   256'(d2_out_inst),    256'(INST_B));
        check("drain_payload_b",256'(d2_out_payload), 256'(PL_B));
        check("drain_count1",   256'(d2_count),       256'(2'd1));
        check("drain_ready",    256'(d2_in_ready),    256'(1'b1));
        step();
        check("drain_nop",     256'(d2_out_inst),    256'(NOP));
        check("drain_empty",   256'(d2_out_valid),   256'(1'b0));
        check("drain_count0",  256'(d2_count),       256'(2'd0));
        check("drain_pl_zero", 256'(d2_out_payload), 256'(0));

        // Load-use hazard
        d2_out_ready = 1'b0;
        d2_push(LW_X5, PL_A);
        d2_dec_inst = ADD_RS1_X5;
        #1 check("haz_rs1", 256'(d2_load_hazard), 256'(1'b1));
        d2_dec_inst = ADD_RS2_X5;
        #1 check("haz_rs2", 256'(d2_load_hazard), 256'(1'b1));
        d2_dec_inst = ADD_X0_X7;
        #1 check("haz_x0_x7", 256'(d2_load_hazard), 256'(1'b0));
        d2_push(FLW_F7, PL_B);
        #1 check("haz_flw_tail", 256'(d2_load_hazard), 256'(1'b1));
        d2_out_ready = 1'b1;
        d2_dec_inst  = ADD_RS1_X5;
        #1 check("haz_head_popping", 256'(d2_load_hazard), 256'(1'b1));
        step();
        d2_out_ready = 1'b0;
        check("haz_after_pop", 256'(d2_load_hazard), 256'(1'b0));
        d2_dec_inst = ADD_X0_X7;
        #1 check("haz_flw_remains", 256'(d2_load_hazard), 256'(1'b1));
        d2_out_ready = 1'b1;
        step();
        d2_out_ready = 1'b0;
        check("haz_all_popped", 256'(d2_load_hazard), 256'(1'b0));
        d2_push(INST_C, PL_A);
        #1 check("haz_non_load", 256'(d2_load_hazard), 256'(1'b0));
        d2_out_ready = 1'b1;
        step();
        d2_out_ready = 1'b0;

        // Flush at count=2 with a concurrent push
        d2_push(INST_A, PL_A);
        d2_push(INST_B, PL_B);
        check("pre_flush_count", 256'(d2_count), 256'(2'd2));
        d2_flush      = 1'b1;
        d2_in_valid   = 1'b1;
        d2_in_inst    = INST_C;
        step();
        d2_flush    = 1'b0;
        d2_in_valid = 1'b0;
        check("flush_count", 256'(d2_count),    256'(2'd0));
        check("flush_inst",  256'(d2_out_inst), 256'(NOP));
        check("flush_ready", 256'(d2_in_ready), 256'(1'b1));
        // Flush at count=1 drops an otherwise acceptable push
        d2_push(INST_A, PL_A);
        d2_flush    = 1'b1;
        d2_in_valid = 1'b1;
        d2_in_inst  = INST_C;
        step();
        d2_flush    = 1'b0;
        d2_in_valid = 1'b0;
        check("flush1_count", 256'(d2_count),     256'(2'd0));
        check("flush1_valid", 256'(d2_out_valid), 256'(1'b0));
        // Pointers restart at 0 after flush
        d2_push(INST_B, PL_B);
        check("post_flush_inst", 256'(d2_out_inst), 256'(INST_B));
        d2_out_ready = 1'b1;
        step();
        d2_out_ready = 1'b0;

        // Async reset mid-stream
        d2_push(INST_A, PL_A);
        d2_push(INST_B, PL_B);
        check("pre_rst_count", 256'(d2_count), 256'(2'd2));
        #2 rst = 1'b0;
        #1;
        check("arst_count", 256'(d2_count),     256'(2'd0));
        check("arst_valid", 256'(d2_out_valid), 256'(1'b0));
        check("arst_inst",  256'(d2_out_inst),  256'(NOP));
        check("arst_ready", 256'(d2_in_ready),  256'(1'b1));
        step();
        rst = 1'b1;
        step();
        check("arst_hold_count", 256'(d2_count), 256'(2'd0));

        // DEPTH=3 wrap-around with steady push/pop pairs
        d3_out_ready  = 1'b1;
        d3_in_valid   = 1'b1;
        d3_in_inst    = wrap_inst(0);
        d3_in_payload = PW'(7);
        step();
        check("wrap_first_count", 256'(d3_count), 256'(2'd1));
        for (int k = 1; k <= 10; k++) begin
            d3_in_inst    = wrap_inst(k);
            d3_in_payload = PW'(k * 3 + 7);
            check($sformatf("wrap_head_%0d", k - 1), 256'(d3_out_inst), 256'(wrap_inst(k - 1)));
            check($sformatf("wrap_pl_%0d", k - 1),   256'(d3_out_payload), 256'(PW'((k - 1) * 3 + 7)));
            step();
            check($sformatf("wrap_count_%0d", k), 256'(d3_count), 256'(2'd1));
        end
        d3_in_valid = 1'b0;
        check("wrap_last_head", 256'(d3_out_inst), 256'(wrap_inst(10)));
        step();
        check("wrap_empty", 256'(d3_out_valid), 256'(1'b0));
        check("wrap_nop",   256'(d3_out_inst),  256'(NOP));
        d3_out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
